rob_retire: RTL and testbench
=============================

// Module: rob_retire
// PURPOSE
//  In-order commit end of the rename path: rename allocates a physical dest (pd) and
//  records the previous mapping (old_pd); this block holds each renamed instr in a
//  circular reorder buffer, accepts out-of-order completion, retires in program order
//  and returns old_pd to the free pool. Sits between rename/dispatch and free-pool/RAT.
// PARAMETERS
//  DEPTH     16  ROB entries; power of 2, >= 4
//  RETIRE_W  2   max instrs retired per cycle
//  PREG_W    6   physical reg index width (64 pregs)
//  AREG_W    5   architectural reg index width
// PORTS
//  clk           in   1                  clock, rising edge
//  rst           in   1                  async reset, active-high
//  alloc_valid   in   1                  rename presents one instr
//  alloc_ready   out  1                  ROB can accept (count != DEPTH)
//  alloc_rd      in   AREG_W             arch dest
//  alloc_has_rd  in   1                  instr writes a register
//  alloc_pd      in   PREG_W             newly allocated preg
//  alloc_old_pd  in   PREG_W             preg previously mapped to rd
//  alloc_tag     out  $clog2(DEPTH)      ROB index given to this instr (= tail)
//  wb_valid      in   1                  execution completion
//  wb_tag        in   $clog2(DEPTH)      ROB index completing
//  ret_valid     out  RETIRE_W           lane i retires this cycle
//  ret_rd        out  RETIRE_W*AREG_W    arch dest per lane (retirement RAT update)
//  ret_pd        out  RETIRE_W*PREG_W    committed preg per lane
//  free_valid    out  RETIRE_W           lane i releases free_pd[i]
//  free_pd       out  RETIRE_W*PREG_W    preg returned to free pool
//  rob_empty     out  1                  count == 0
//  rob_count     out  $clog2(DEPTH)+1    occupied entries
// BEHAVIOUR
//  Reset (async, rst=1): head=tail=count=0; all entry valid/done bits 0; alloc_ready=1,
//   rob_empty=1, rob_count=0, ret_valid=0, free_valid=0, data outputs 0. Release
//   mid-operation discards all entries; no retire until new allocs complete.
//  Alloc: on edge with alloc_valid && alloc_ready, entry[tail] <= {valid=1, done=0, rd,
//   has_rd, pd, old_pd}; tail <= tail+1 mod DEPTH. alloc_ready is from registered count
//   only: no same-cycle bypass of retiring slots; full ROB stalls even if head retires.
//  alloc_valid while !alloc_ready: no state change.
//  Writeback: on edge with wb_valid, entry[wb_tag].done <= 1 if entry valid; wb to an
//   invalid entry is ignored. Duplicate wb is harmless.
//  Retire (combinational from registered state): lane i valid iff entry[head+i] valid
//   && done && lanes 0..i-1 valid; indices wrap mod DEPTH. Strictly in order: an
//   incomplete head blocks all younger lanes. On the edge, retired entries clear
//   valid/done, head advances by number retired.
//  Latency: wb at edge E -> ret_valid high in cycle after E (1 cycle); alloc -> earliest
//   retire is 2 cycles (alloc edge, wb edge, then retire).
//  Free: free_valid[i] = ret_valid[i] && has_rd && rd != 0; free_pd[i] = old_pd. x0
//   and no-dest instrs never release a preg.
//  Count: count <= count + alloc_fire - num_retired; all in the same edge, no overflow
//   since alloc is gated by registered count. Simultaneous alloc+retire+wb to different
//   entries all take effect; wb to the entry retiring that cycle cannot occur (already done).
//  Retirement of an entry allocated this same edge is impossible (done=0 at alloc).
// STRUCTURE
//  Shared package rob_pkg: PREG_W, AREG_W, ROB_DEPTH constants; rob_entry_t struct
//   {valid, done, has_rd, rd, pd, old_pd}; rob_tag_t typedef.
//  One sub-module: rob_retire_sel (combinational head-window scan producing ret_valid
//   and num_retired for RETIRE_W lanes). Entry array, pointers, count in top module.
// TESTING
//  1. Reset: rst pulse mid-traffic -> ret_valid=0, rob_empty=1, alloc_ready=1, alloc_tag=0.
//  2. Alloc 3 (rd=5,pd=33,old=5), wb tags 0,1 same cycle-pair -> next cycle ret_valid=2'b11,
//     free_pd={old1,5}; tag 2 still held, count=1.
//  3. Out of order: wb tag1 then tag2, tag0 last -> no retire until tag0 done; then 2
//     retire, third retires next cycle.
//  4. Full: 16 allocs -> alloc_ready=0; 17th alloc_valid ignored; retire 2 -> ready=1
//     one cycle later; tail wraps to 0 correctly.
//  5. rd=0 / has_rd=0 entries retire with ret_valid=1 but free_valid=0.
//  6. Wrap: head=15, entries 15 and 0 done -> both retire, head=1.

Source files
------------

// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared widths, ROB entry layout and tag type for the reorder buffer
package rob_pkg;
    localparam int ROB_DEPTH = 16;
    localparam int PREG_W    = 6;
    localparam int AREG_W    = 5;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_rd;
        logic [AREG_W-1:0] rd;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] old_pd;
    } rob_entry_t;

    // Only real destinations other than x0 hand their previous preg back.
    function automatic logic frees_preg(input rob_entry_t e);
        return e.has_rd && (e.rd != '0);
    endfunction
endpackage

// File: rtl/rob_retire_sel.sv
// rtl/rob_retire_sel.sv - in-order head-window scan selecting retiring lanes
module rob_retire_sel #(
    parameter int DEPTH    = 16,
    parameter int RETIRE_W = 2
) (
    input  logic [$clog2(DEPTH)-1:0]      head,
    input  logic [DEPTH-1:0]              valid_vec,
    input  logic [DEPTH-1:0]              done_vec,
    output logic [RETIRE_W-1:0]           ret_valid,
    output logic [$clog2(RETIRE_W+1)-1:0] num_retired
);
    localparam int TW = $clog2(DEPTH);
    localparam int NW = $clog2(RETIRE_W + 1);

    always_comb begin
        logic          chain;
        logic [TW-1:0] idx;
        ret_valid   = '0;
        num_retired = '0;
        chain       = 1'b1;
        idx         = '0;
        // An incomplete older entry breaks the chain for every younger lane.
        for (int i = 0; i < RETIRE_W; i++) begin
            idx          = head + TW'(i);
            chain        = chain && valid_vec[idx] && done_vec[idx];
            ret_valid[i] = chain;
            if (chain) begin
                num_retired = num_retired + NW'(1);
            end
        end
    end
endmodule

// File: rtl/rob_retire.sv
// rtl/rob_retire.sv - circular reorder buffer with out-of-order completion and in-order retire
module rob_retire
    import rob_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH,
    parameter int RETIRE_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [AREG_W-1:0]            alloc_rd,
    input  logic                         alloc_has_rd,
    input  logic [PREG_W-1:0]            alloc_pd,
    input  logic [PREG_W-1:0]            alloc_old_pd,
    output logic [$clog2(DEPTH)-1:0]     alloc_tag,
    input  logic                         wb_valid,
    input  logic [$clog2(DEPTH)-1:0]     wb_tag,
    output logic [RETIRE_W-1:0]          ret_valid,
    output logic [RETIRE_W*AREG_W-1:0]   ret_rd,
    output logic [RETIRE_W*PREG_W-1:0]   ret_pd,
    output logic [RETIRE_W-1:0]          free_valid,
    output logic [RETIRE_W*PREG_W-1:0]   free_pd,
    output logic                         rob_empty,
    output logic [$clog2(DEPTH):0]       rob_count
);
    localparam int TW = $clog2(DEPTH);
    localparam int NW = $clog2(RETIRE_W + 1);

    rob_entry_t     entries [DEPTH];
    logic [TW-1:0]  head;
    logic [TW-1:0]  tail;
    logic [TW:0]    count;
    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] done_vec;
    logic [NW-1:0]  num_retired;
    logic           alloc_fire;

    always_comb begin
        valid_vec = '0;
        done_vec  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entries[i].valid;
            done_vec[i]  = entries[i].done;
        end
    end

    rob_retire_sel #(
        .DEPTH    (DEPTH),
        .RETIRE_W (RETIRE_W)
    ) u_sel (
        .head        (head),
        .valid_vec   (valid_vec),
        .done_vec    (done_vec),
        .ret_valid   (ret_valid),
        .num_retired (num_retired)
    );

    // Readiness looks only at the registered count; a retiring slot is not reused this cycle.
    assign alloc_ready = (count != (TW+1)'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = tail;
    assign rob_empty   = (count == '0);
    assign rob_count   = count;

    always_comb begin
        rob_entry_t e;
        e          = '0;
        ret_rd     = '0;
        ret_pd     = '0;
        free_valid = '0;
        free_pd    = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            e = entries[head + TW'(i)];
            if (ret_valid[i]) begin
                ret_rd[i*AREG_W +: AREG_W] = e.rd;
                ret_pd[i*PREG_W +: PREG_W] = e.pd;
                if (frees_preg(e)) begin
                    free_valid[i]               = 1'b1;
                    free_pd[i*PREG_W +: PREG_W] = e.old_pd;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (wb_valid && entries[wb_tag].valid) begin
                entries[wb_tag].done <= 1'b1;
            end
            for (int i = 0; i < RETIRE_W; i++) begin
                if (ret_valid[i]) begin
                    entries[head + TW'(i)] <= '0;
                end
            end
            // The tail slot is never a retiring slot: a full ROB blocks the alloc.
            if (alloc_fire) begin
                entries[tail] <= '{valid: 1'b1, done: 1'b0, has_rd: alloc_has_rd,
                                   rd: alloc_rd, pd: alloc_pd, old_pd: alloc_old_pd};
            end
            head  <= head + TW'(num_retired);
            tail  <= tail + TW'(alloc_fire);
            count <= count + (TW+1)'(alloc_fire) - (TW+1)'(num_retired);
        end
    end
endmodule

// File: tb/tb_rob_retire.sv
// tb/tb_rob_retire.sv - randomized bench for rob_retire against a program-order queue model
module tb_rob_retire;
    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [4:0]  alloc_rd;
    logic        alloc_has_rd;
    logic [5:0]  alloc_pd;
    logic [5:0]  alloc_old_pd;
    logic [3:0]  alloc_tag;
    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic [1:0]  ret_valid;
    logic [9:0]  ret_rd;
    logic [11:0] ret_pd;
    logic [1:0]  free_valid;
    logic [11:0] free_pd;
    logic        rob_empty;
    logic [4:0]  rob_count;

    rob_retire dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_rd     (alloc_rd),
        .alloc_has_rd (alloc_has_rd),
        .alloc_pd     (alloc_pd),
        .alloc_old_pd (alloc_old_pd),
        .alloc_tag    (alloc_tag),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .ret_valid    (ret_valid),
        .ret_rd       (ret_rd),
        .ret_pd       (ret_pd),
        .free_valid   (free_valid),
        .free_pd      (free_pd),
        .rob_empty    (rob_empty),
        .rob_count    (rob_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int rd;
        bit has_rd;
        int pd;
        int old_pd;
        bit done;
    } m_ent_t;

    m_ent_t mq[$];
    int     next_tag;
    int     n_checks;
    int     n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_ret_valid", 32'(ret_valid), 32'd0);
        check("rst_free_valid", 32'(free_valid), 32'd0);
        check("rst_empty", 32'(rob_empty), 32'd1);
        check("rst_ready", 32'(alloc_ready), 32'd1);
        check("rst_tag", 32'(alloc_tag), 32'd0);
        check("rst_count", 32'(rob_count), 32'd0);
        check("rst_ret_pd", 32'(ret_pd), 32'd0);
    endtask

    // Called at a falling edge: check outputs, drive next inputs, advance the model one edge.
    task automatic step(input int alloc_pct, input int wb_pct);
        int         nret;
        int         sz;
        bit         ready;
        logic [1:0] e_rv;
        logic [1:0] e_fv;
        logic [9:0] e_rd;
        logic [11:0] e_pd;
        logic [11:0] e_fpd;
        nret  = 0;
        e_rv  = '0;
        e_fv  = '0;
        e_rd  = '0;
        e_pd  = '0;
        e_fpd = '0;
        sz    = mq.size();
        ready = (sz != 16);
        for (int l = 0; l < 2; l++) begin
            if (nret == l && l < sz && mq[l].done) begin
                nret++;
                e_rv[l] = 1'b1;
                e_rd[l*5 +: 5] = 5'(mq[l].rd);
                e_pd[l*6 +: 6] = 6'(mq[l].pd);
                if (mq[l].has_rd && mq[l].rd != 0) begin
                    e_fv[l] = 1'b1;
                    e_fpd[l*6 +: 6] = 6'(mq[l].old_pd);
                end
            end
        end
        check("alloc_ready", 32'(alloc_ready), 32'(ready));
        check("rob_count", 32'(rob_count), 32'(sz));
        check("rob_empty", 32'(rob_empty), 32'(sz == 0));
        check("alloc_tag", 32'(alloc_tag), 32'(next_tag % 16));
        check("ret_valid", 32'(ret_valid), 32'(e_rv));
        check("ret_rd", 32'(ret_rd), 32'(e_rd));
        check("ret_pd", 32'(ret_pd), 32'(e_pd));
        check("free_valid", 32'(free_valid), 32'(e_fv));
        check("free_pd", 32'(free_pd), 32'(e_fpd));

        alloc_valid  = ($urandom_range(0, 99) < alloc_pct);
        alloc_rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        alloc_has_rd = ($urandom_range(0, 4) != 0);
        alloc_pd     = 6'($urandom_range(0, 63));
        alloc_old_pd = 6'($urandom_range(0, 63));
        wb_valid     = ($urandom_range(0, 99) < wb_pct);
        if (sz > 0 && $urandom_range(0, 9) != 0)
            wb_tag = 4'(mq[$urandom_range(0, sz - 1)].tag);
        else
            wb_tag = 4'($urandom_range(0, 15));

        for (int l = 0; l < nret; l++) void'(mq.pop_front());
        if (wb_valid) begin
            foreach (mq[k]) if (mq[k].tag == int'(wb_tag)) mq[k].done = 1'b1;
        end
        if (alloc_valid && ready) begin
            mq.push_back('{tag: next_tag % 16, rd: int'(alloc_rd), has_rd: alloc_has_rd,
                           pd: int'(alloc_pd), old_pd: int'(alloc_old_pd), done: 1'b0});
            next_tag++;
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        next_tag     = 0;
        rst          = 1'b1;
        alloc_valid  = 1'b0;
        alloc_rd     = '0;
        alloc_has_rd = 1'b0;
        alloc_pd     = '0;
        alloc_old_pd = '0;
        wb_valid     = 1'b0;
        wb_tag       = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        repeat (200) step(85, 15);
        repeat (200) step(30, 80);
        repeat (300) step(60, 60);

        rst = 1'b1;
        #1;
        check_reset_outputs();
        mq.delete();
        next_tag    = 0;
        alloc_valid = 1'b0;
        wb_valid    = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        repeat (300) step(90, 40);
        repeat (200) step(50, 95);
        repeat (60) step(0, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
